bp_io_host_encoder: RTL and testbench



---
 rtl/bp_io_host_encoder.sv | 192 +++++++++++++++++++
 tb/tb_bp_io_host_encoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_io_host_encoder.sv
// Host-to-BlackParrot bridge: decodes 32-bit host words into BedRock uncached I/O commands and returns read data.
// Optional response watchdog and late-response drain are enabled with `define BP_IO_HOST_TIMEOUT_EN.
module bp_io_host_encoder
    #(parameter int paddr_width_p         = 40
    , parameter int lce_id_width_p        = 4
    , parameter int lce_assoc_p           = 8
    , parameter int uce_mem_data_width_lp = 64
    , parameter logic [paddr_width_p-1:0]  base_addr_p = '0
    , parameter logic [lce_id_width_p-1:0] lce_id_p    = '0
    , parameter int timeout_cycles_p      = 1024
    , localparam int way_id_width_lp      = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1
    , localparam int payload_width_lp     = lce_id_width_p + way_id_width_lp + 5
    , localparam int header_width_lp      = 4 + 4 + paddr_width_p + 3 + payload_width_lp
    , localparam int uce_mem_msg_width_lp = uce_mem_data_width_lp + header_width_lp
    )
    (input  logic                            clk_i
    , input  logic                            reset_i
    , input  logic [31:0]                     data_i
    , input  logic                            v_i
    , output logic                            ready_and_o
    , output logic [uce_mem_msg_width_lp-1:0] io_cmd_o
    , output logic                            io_cmd_v_o
    , input  logic                            io_cmd_ready_and_i
    , input  logic [uce_mem_msg_width_lp-1:0] io_resp_i
    , input  logic                            io_resp_v_i
    , output logic                            io_resp_yumi_o
    , output logic [31:0]                     data_o
    , output logic                            v_o
    , input  logic                            ready_i
    );

    typedef enum logic [1:0] {e_ready, e_send, e_wait, e_return} state_e;

    localparam logic [3:0] e_bedrock_mem_uc_rd  = 4'b0010;
    localparam logic [3:0] e_bedrock_mem_uc_wr  = 4'b0011;
    localparam logic [2:0] e_bedrock_msg_size_1 = 3'b000;

    // Header packs {payload, size, addr, subop, msg_type} from MSB to LSB; data sits above the header.
    localparam int addr_lsb_lp   = 8;
    localparam int size_lsb_lp   = addr_lsb_lp + paddr_width_p;
    localparam int lce_id_lsb_lp = header_width_lp - lce_id_width_p;
    localparam int data_lsb_lp   = header_width_lp;

    state_e      state_r, state_n_s;
    logic        write_r;
    logic [22:0] addr_r;
    logic [7:0]  wdata_r;
    logic [7:0]  rdata_r;
    logic        err_r;

    logic [uce_mem_msg_width_lp-1:0] cmd_s;
    logic [7:0] resp_byte_s;
    logic       accept_s;
    logic       wait_yumi_s;
    logic       timeout_s;
    logic       unused_s;

    assign resp_byte_s = io_resp_i[data_lsb_lp +: 8];
    assign accept_s    = (state_r == e_ready) & v_i;
    assign wait_yumi_s = (state_r == e_wait) & io_resp_v_i;

`ifdef BP_IO_HOST_TIMEOUT_EN
    localparam int cnt_width_lp = $clog2(timeout_cycles_p + 1);
    localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(timeout_cycles_p - 1);

    logic [cnt_width_lp-1:0] cnt_r;

    // The limit is reached by the increment of an unanswered e_wait cycle, so a response that cycle wins.
    assign timeout_s = (state_r == e_wait) & ~io_resp_v_i & (cnt_r == cnt_last_lp);

    // Watchdog: clears on entry to e_wait, counts e_wait cycles without a response.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_r <= '0;
        end else if ((state_r == e_send) && io_cmd_ready_and_i) begin
            cnt_r <= '0;
        end else if ((state_r == e_wait) && !io_resp_v_i) begin
            cnt_r <= cnt_r + cnt_width_lp'(1);
        end
    end

    assign unused_s = ^{io_resp_i[uce_mem_msg_width_lp-1:data_lsb_lp+8], io_resp_i[data_lsb_lp-1:0]};
`else
    assign timeout_s = 1'b0;
    assign unused_s  = ^{io_resp_i[uce_mem_msg_width_lp-1:data_lsb_lp+8], io_resp_i[data_lsb_lp-1:0],
                         (timeout_cycles_p > 0)};
`endif

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_ready;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Captures the host word, the response byte, and the error flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            write_r <= 1'b0;
            addr_r  <= 23'h0;
            wdata_r <= 8'h00;
            rdata_r <= 8'h00;
            err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                write_r <= data_i[31];
                addr_r  <= data_i[30:8];
                wdata_r <= data_i[7:0];
                err_r   <= 1'b0;
            end
            if (wait_yumi_s) begin
                rdata_r <= resp_byte_s;
                err_r   <= 1'b0;
            end else if (timeout_s) begin
                rdata_r <= write_r ? 8'h00 : 8'hFF;
                err_r   <= 1'b1;
            end
        end
    end

    // Builds the BedRock uncached command from the registered host word.
    always_comb begin
        cmd_s = '0;
        cmd_s[3:0] = write_r ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
        cmd_s[addr_lsb_lp +: paddr_width_p] = base_addr_p | {{(paddr_width_p-23){1'b0}}, addr_r};
        cmd_s[size_lsb_lp +: 3] = e_bedrock_msg_size_1;
        cmd_s[lce_id_lsb_lp +: lce_id_width_p] = lce_id_p;
        cmd_s[data_lsb_lp +: 8] = write_r ? wdata_r : 8'h00;
    end

    // Next-state and output decode; every output is forced low while reset is asserted.
    always_comb begin
        state_n_s      = state_r;
        ready_and_o    = 1'b0;
        io_cmd_v_o     = 1'b0;
        io_cmd_o       = '0;
        io_resp_yumi_o = 1'b0;
        v_o            = 1'b0;
        data_o         = 32'h0;
        if (reset_i) begin
            state_n_s = e_ready;
        end else begin
            case (state_r)
                e_ready: begin
                    ready_and_o = 1'b1;
`ifdef BP_IO_HOST_TIMEOUT_EN
                    io_resp_yumi_o = io_resp_v_i;
`endif
                    if (v_i) begin
                        state_n_s = e_send;
                    end else begin
                        state_n_s = e_ready;
                    end
                end
                e_send: begin
                    io_cmd_v_o = 1'b1;
                    io_cmd_o   = cmd_s;
                    if (io_cmd_ready_and_i) begin
                        state_n_s = e_wait;
                    end else begin
                        state_n_s = e_send;
                    end
                end
                e_wait: begin
                    io_resp_yumi_o = io_resp_v_i;
                    if (io_resp_v_i) begin
                        state_n_s = write_r ? e_ready : e_return;
                    end else if (timeout_s) begin
                        state_n_s = e_return;
                    end else begin
                        state_n_s = e_wait;
                    end
                end
                e_return: begin
                    v_o    = 1'b1;
                    data_o = {err_r, addr_r, rdata_r};
                    if (ready_i) begin
                        state_n_s = e_ready;
                    end else begin
                        state_n_s = e_return;
                    end
                end
                default: begin
                    state_n_s = e_ready;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_io_host_encoder.sv
// Self-checking bench for bp_io_host_encoder: vector table plus scoreboard queues for commands and host words.
// Timeout scenarios run only when BP_IO_HOST_TIMEOUT_EN is defined.
module tb_bp_io_host_encoder;

    localparam int MW = 127;
    localparam logic [39:0] BASE = 40'h00_1000_0000;
    localparam logic [3:0]  LCE  = 4'h5;

    logic          clk;
    logic          reset_i;
    logic [31:0]   data_i;
    logic          v_i;
    logic          ready_and_o;
    logic [MW-1:0] io_cmd_o;
    logic          io_cmd_v_o;
    logic          io_cmd_ready_and_i;
    logic [MW-1:0] io_resp_i;
    logic          io_resp_v_i;
    logic          io_resp_yumi_o;
    logic [31:0]   data_o;
    logic          v_o;
    logic          ready_i;

    bp_io_host_encoder #(
        .paddr_width_p(40), .lce_id_width_p(4), .lce_assoc_p(8), .uce_mem_data_width_lp(64),
        .base_addr_p(BASE), .lce_id_p(LCE), .timeout_cycles_p(8)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .ready_and_o(ready_and_o),
        .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_and_i(io_cmd_ready_and_i),
        .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
        .data_o(data_o), .v_o(v_o), .ready_i(ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] word;
        logic [7:0]  resp_byte;
        int          cmd_delay;
        int          host_delay;
        bit          hold;
        logic [3:0]  exp_type;
        logic [39:0] exp_addr;
        logic [7:0]  exp_byte;
        logic [31:0] exp_host;
    } vec_t;

    vec_t vecs[8];
    int total = 0;
    int bad = 0;
    logic [51:0] cmd_q[$];
    logic [31:0] host_q[$];
    logic outstanding = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops expectations on each command and host-word handshake.
    always @(negedge clk) begin
        logic [51:0] e;
        logic [31:0] h;
        if (reset_i) begin
            outstanding <= 1'b0;
        end else begin
            if (io_cmd_v_o && io_cmd_ready_and_i) begin
                check("cmd_single_outstanding", {127'h0, outstanding}, 128'h0);
                outstanding <= 1'b1;
                if (cmd_q.size() == 0) begin
                    check("cmd_unexpected", 128'h1, 128'h0);
                end else begin
                    e = cmd_q.pop_front();
                    check("cmd_type", io_cmd_o[3:0], e[51:48]);
                    check("cmd_subop", io_cmd_o[7:4], 128'h0);
                    check("cmd_addr", io_cmd_o[47:8], e[47:8]);
                    check("cmd_size", io_cmd_o[50:48], 128'h0);
                    check("cmd_payload_rest", io_cmd_o[58:51], 128'h0);
                    check("cmd_lce_id", io_cmd_o[62:59], LCE);
                    check("cmd_byte", io_cmd_o[70:63], e[7:0]);
                    check("cmd_data_hi", io_cmd_o[126:71], 128'h0);
                end
            end
            if (io_resp_v_i && io_resp_yumi_o) begin
                outstanding <= 1'b0;
            end
            if (v_o && ready_i) begin
                if (host_q.size() == 0) begin
                    check("host_unexpected", {96'h0, data_o}, 128'h0);
                end else begin
                    h = host_q.pop_front();
                    check("host_word", data_o, h);
                end
            end
        end
    end

    task automatic do_txn(input vec_t v, input logic [31:0] next_word);
        logic [MW-1:0] snap;
        logic [MW-1:0] resp;
        data_i = v.word;
        v_i = 1'b1;
        check("ready_idle", ready_and_o, 128'h1);
        cmd_q.push_back({v.exp_type, v.exp_addr, v.exp_byte});
        if (!v.word[31]) host_q.push_back(v.exp_host);
        tick();
        if (v.hold) begin
            data_i = next_word;
        end else begin
            v_i = 1'b0;
            data_i = 32'hDEAD_BEEF;
        end
        check("cmd_v_next_cycle", io_cmd_v_o, 128'h1);
        snap = io_cmd_o;
        for (int i = 0; i < v.cmd_delay; i++) begin
            io_cmd_ready_and_i = 1'b0;
            check("cmd_held", io_cmd_o, snap);
            check("cmd_v_held", io_cmd_v_o, 128'h1);
            check("ready_busy", ready_and_o, 128'h0);
            tick();
        end
        io_cmd_ready_and_i = 1'b1;
        check("ready_busy_send", ready_and_o, 128'h0);
        check("cmd_stable", io_cmd_o, snap);
        tick();
        io_cmd_ready_and_i = 1'b0;
        resp = '1;
        resp[70:63] = v.resp_byte;
        io_resp_i = resp;
        io_resp_v_i = 1'b1;
        #1;
        check("yumi_in_wait", io_resp_yumi_o, 128'h1);
        tick();
        io_resp_v_i = 1'b0;
        io_resp_i = '0;
        if (v.word[31]) begin
            check("write_ready_back", ready_and_o, 128'h1);
            check("write_no_v_o", v_o, 128'h0);
        end else begin
            check("read_v_o", v_o, 128'h1);
            check("read_data", data_o, v.exp_host);
            for (int i = 0; i < v.host_delay; i++) begin
                ready_i = 1'b0;
                check("ret_data_held", data_o, v.exp_host);
                check("ret_v_held", v_o, 128'h1);
                check("ret_ready_busy", ready_and_o, 128'h0);
                tick();
            end
            ready_i = 1'b1;
            tick();
            ready_i = 1'b0;
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{32'h8001_2345, 8'h00, 0, 0, 1'b0, 4'h3, 40'h00_1000_0123, 8'h45, 32'h0};
        vecs[1] = '{32'h0000_0100, 8'h5A, 0, 0, 1'b0, 4'h2, 40'h00_1000_0001, 8'h00, 32'h0000_015A};
        vecs[2] = '{32'h7FFF_FF00, 8'hC3, 5, 3, 1'b0, 4'h2, 40'h00_107F_FFFF, 8'h00, 32'h7FFF_FFC3};
        vecs[3] = '{32'hFFFF_FFAA, 8'h00, 5, 0, 1'b0, 4'h3, 40'h00_107F_FFFF, 8'hAA, 32'h0};
        vecs[4] = '{32'h8000_0111, 8'h00, 0, 0, 1'b1, 4'h3, 40'h00_1000_0001, 8'h11, 32'h0};
        vecs[5] = '{32'h0000_0500, 8'h77, 0, 0, 1'b1, 4'h2, 40'h00_1000_0005, 8'h00, 32'h0000_0577};
        vecs[6] = '{32'h8000_0333, 8'h00, 0, 0, 1'b1, 4'h3, 40'h00_1000_0003, 8'h33, 32'h0};
        vecs[7] = '{32'h8000_0444, 8'h00, 0, 0, 1'b0, 4'h3, 40'h00_1000_0004, 8'h44, 32'h0};

        reset_i = 1'b1;
        data_i = 32'h0;
        v_i = 1'b0;
        io_cmd_ready_and_i = 1'b0;
        io_resp_i = '0;
        io_resp_v_i = 1'b0;
        ready_i = 1'b0;
        tick();
        tick();
        check("rst_ready", ready_and_o, 128'h0);
        check("rst_cmd_v", io_cmd_v_o, 128'h0);
        check("rst_cmd", io_cmd_o, 128'h0);
        check("rst_v_o", v_o, 128'h0);
        check("rst_data_o", data_o, 128'h0);
        reset_i = 1'b0;
        #1;
        check("ready_after_rst", ready_and_o, 128'h1);
        tick();

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i], (i < 7) ? vecs[(i < 7) ? i + 1 : i].word : 32'h0);
        end

        // Reset while a read waits for its response: nothing partial may come back.
        data_i = 32'h0000_0200;
        v_i = 1'b1;
        cmd_q.push_back({4'h2, 40'h00_1000_0002, 8'h00});
        tick();
        v_i = 1'b0;
        io_cmd_ready_and_i = 1'b1;
        tick();
        io_cmd_ready_and_i = 1'b0;
        tick();
        reset_i = 1'b1;
        io_resp_v_i = 1'b1;
        #1;
        check("midrst_ready", ready_and_o, 128'h0);
        check("midrst_cmd_v", io_cmd_v_o, 128'h0);
        check("midrst_yumi", io_resp_yumi_o, 128'h0);
        check("midrst_v_o", v_o, 128'h0);
        check("midrst_data_o", data_o, 128'h0);
        check("midrst_cmd", io_cmd_o, 128'h0);
        tick();
        check("midrst_yumi_held", io_resp_yumi_o, 128'h0);
        reset_i = 1'b0;
        io_resp_v_i = 1'b0;
        #1;
        check("midrst_ready_release", ready_and_o, 128'h1);
        tick();
        check("midrst_no_partial", v_o, 128'h0);

        // Unsolicited response while idle.
        io_resp_i = '1;
        io_resp_v_i = 1'b1;
        #1;
`ifdef BP_IO_HOST_TIMEOUT_EN
        check("idle_drain_yumi", io_resp_yumi_o, 128'h1);
`else
        check("idle_no_yumi", io_resp_yumi_o, 128'h0);
`endif
        tick();
        io_resp_v_i = 1'b0;
        io_resp_i = '0;
        check("idle_ready_kept", ready_and_o, 128'h1);
        check("idle_no_v_o", v_o, 128'h0);

`ifdef BP_IO_HOST_TIMEOUT_EN
        // Unanswered read times out after eight e_wait cycles, then the late response is drained.
        data_i = 32'h0000_0A00;
        v_i = 1'b1;
        cmd_q.push_back({4'h2, 40'h00_1000_000A, 8'h00});
        tick();
        v_i = 1'b0;
        io_cmd_ready_and_i = 1'b1;
        tick();
        io_cmd_ready_and_i = 1'b0;
        n = 0;
        while (!v_o && n < 50) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 128'd8);
        check("timeout_data", data_o, 32'h8000_0AFF);
        host_q.push_back(32'h8000_0AFF);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        io_resp_i = '0;
        io_resp_v_i = 1'b1;
        #1;
        check("late_resp_yumi", io_resp_yumi_o, 128'h1);
        tick();
        io_resp_v_i = 1'b0;
        check("late_resp_no_v_o", v_o, 128'h0);
        check("late_resp_ready", ready_and_o, 128'h1);
`else
        n = 0;
`endif

        tick();
        check("cmd_q_drained", cmd_q.size(), 128'h0);
        check("host_q_drained", host_q.size(), 128'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
